// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register file write-port arbiter
// Arbitrates the single write port: wb > clear sequencer > debug.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  dbg_valid,
  output logic                  dbg_ready,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  zero_drop,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_data
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NREG - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_idx, w_clr_idx_nxt;
  logic                  r_clr_done, w_clr_done_nxt;
  logic                  w_dbg_ready;
  logic                  w_dbg_xfer;

  assign w_dbg_ready = (r_state == S_IDLE) && !clr_start && !wb_we;
  assign w_dbg_xfer  = dbg_valid && w_dbg_ready;
  assign dbg_ready   = w_dbg_ready;
  assign clr_busy    = (r_state == S_CLEAR);
  assign clr_done    = r_clr_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_clr_idx  <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_idx  <= w_clr_idx_nxt;
      r_clr_done <= w_clr_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_idx_nxt  = r_clr_idx;
    w_clr_done_nxt = 1'b0;
    rf_we          = 1'b0;
    rf_addr        = '0;
    rf_data        = '0;
    zero_drop      = 1'b0;

    if (wb_we) begin
      rf_addr   = wb_addr;
      rf_data   = wb_data;
      rf_we     = (wb_addr != '0);
      zero_drop = (wb_addr == '0);
    end else if (r_state == S_CLEAR) begin
      rf_we   = 1'b1;
      rf_addr = r_clr_idx;
    end else if (w_dbg_xfer) begin
      rf_addr   = dbg_addr;
      rf_data   = dbg_data;
      rf_we     = (dbg_addr != '0);
      zero_drop = (dbg_addr == '0);
    end

    // A start coinciding with the done pulse is dropped so a sequence cannot chain back-to-back.
    case (r_state)
      S_IDLE: begin
        if (clr_start && !r_clr_done) begin
          w_state_nxt   = S_CLEAR;
          w_clr_idx_nxt = ADDR_WIDTH'(1);
        end
      end
      S_CLEAR: begin
        if (!wb_we) begin
          if (r_clr_idx == LAST_IDX) begin
            w_state_nxt    = S_IDLE;
            w_clr_idx_nxt  = '0;
            w_clr_done_nxt = 1'b1;
          end else begin
            w_clr_idx_nxt = r_clr_idx + ADDR_WIDTH'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
module tb_regfile_write_arbiter;

  localparam int NREG = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, dbg_valid, clr_start;
  logic [4:0]  wb_addr, dbg_addr;
  logic [31:0] wb_data, dbg_data;
  logic        dbg_ready, clr_busy, clr_done, zero_drop, rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] regs [NREG];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .zero_drop(zero_drop),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  // Register file commits on the falling edge.
  always @(negedge clk) if (rf_we) regs[rf_addr] <= rf_data;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        dbg_valid;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rdy;
    logic        e_zd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seq(input int stall_from, input int stall_n, input bit hold_dbg);
    int  exp_idx;
    int  busy_n;
    bit  seen;
    bit  stall;
    clr_start = 1'b1;
    if (hold_dbg) begin
      dbg_valid = 1'b1; dbg_addr = 5'd10; dbg_data = 32'd7;
    end
    #3;
    chk("start_busy", clr_busy, 0);
    chk("start_rf_we", rf_we, 0);
    if (hold_dbg) chk("start_dbg_ready", dbg_ready, 0);
    next_cycle();
    exp_idx = 1; busy_n = 0; seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      stall   = (c >= stall_from) && (c < stall_from + stall_n);
      wb_we   = stall; wb_addr = 5'd20; wb_data = 32'hAB;
      clr_start = (exp_idx == NREG) ? !hold_dbg : (c == 3);
      #3;
      if (exp_idx == NREG) begin
        seen = 1;
        chk("done_pulse", clr_done, 1);
        chk("done_busy", clr_busy, 0);
        if (hold_dbg) begin
          chk("done_dbg_ready", dbg_ready, 1);
          chk("done_dbg_we", rf_we, 1);
          chk("done_dbg_addr", rf_addr, 10);
          chk("done_dbg_data", rf_data, 7);
        end else begin
          chk("done_rf_we", rf_we, 0);
        end
      end else begin
        busy_n++;
        chk("clr_busy", clr_busy, 1);
        chk("clr_done_early", clr_done, 0);
        if (stall) begin
          chk("stall_addr", rf_addr, 20);
          chk("stall_data", rf_data, 32'hAB);
        end else begin
          chk("clr_we", rf_we, 1);
          chk("clr_addr", rf_addr, exp_idx);
          chk("clr_data", rf_data, 0);
          exp_idx++;
        end
        if (hold_dbg) chk("clr_dbg_ready", dbg_ready, 0);
      end
      next_cycle();
    end
    clr_start = 1'b0; dbg_valid = 1'b0; wb_we = 1'b0;
    chk("clr_cycles", busy_n, 31 + stall_n);
    #3;
    chk("after_busy", clr_busy, 0);
    chk("after_done", clr_done, 0);
    next_cycle();
  endtask

  initial begin
    bit found;
    vecs[0] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        1, 0};
    vecs[1] = '{1, 5'd7,  32'h11,       0, 5'd0,  32'h0,    1, 5'd7,  32'h11,       0, 0};
    vecs[2] = '{1, 5'd0,  32'h22,       0, 5'd0,  32'h0,    0, 5'd0,  32'h22,       0, 1};
    vecs[3] = '{0, 5'd0,  32'h0,        1, 5'd10, 32'h1234, 1, 5'd10, 32'h1234,     1, 0};
    vecs[4] = '{0, 5'd0,  32'h0,        0, 5'd10, 32'h55,   0, 5'd0,  32'h0,        1, 0};
    vecs[5] = '{1, 5'd31, 32'hFFFFFFFF, 1, 5'd4,  32'h44,   1, 5'd31, 32'hFFFFFFFF, 0, 0};
    vecs[6] = '{1, 5'd0,  32'h66,       1, 5'd5,  32'h77,   0, 5'd0,  32'h66,       0, 1};

    rst = 1'b1; wb_we = 0; wb_addr = 0; wb_data = 0;
    dbg_valid = 0; dbg_addr = 0; dbg_data = 0; clr_start = 0;
    #3;
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_dbg_ready", dbg_ready, 1);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 7; i++) begin
      wb_we = vecs[i].wb_we; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
      dbg_valid = vecs[i].dbg_valid; dbg_addr = vecs[i].dbg_addr; dbg_data = vecs[i].dbg_data;
      #3;
      chk($sformatf("vec%0d_we", i), rf_we, vecs[i].e_we);
      chk($sformatf("vec%0d_addr", i), rf_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_data", i), rf_data, vecs[i].e_data);
      chk($sformatf("vec%0d_rdy", i), dbg_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_zd", i), zero_drop, vecs[i].e_zd);
      next_cycle();
    end

    // wb wins over a pending debug request, debug goes the first free cycle
    wb_we = 1; wb_addr = 5'd9; wb_data = 32'd5;
    dbg_valid = 1; dbg_addr = 5'd3; dbg_data = 32'h33;
    #3;
    chk("wbdbg_we", rf_we, 1);
    chk("wbdbg_addr", rf_addr, 9);
    chk("wbdbg_data", rf_data, 5);
    chk("wbdbg_rdy", dbg_ready, 0);
    next_cycle();
    wb_we = 0;
    #3;
    chk("dbg_after_rdy", dbg_ready, 1);
    chk("dbg_after_addr", rf_addr, 3);
    chk("dbg_after_data", rf_data, 32'h33);
    next_cycle();
    dbg_valid = 0;
    chk("reg9_pre", regs[9], 5);
    chk("reg10_pre", regs[10], 32'h1234);

    clear_seq(99, 0, 0);
    chk("reg9_cleared", regs[9], 0);
    chk("reg10_cleared", regs[10], 0);

    clear_seq(5, 3, 0);

    dbg_valid = 1; dbg_addr = 5'd0; dbg_data = 32'hDEADBEEF;
    #3;
    chk("dbg0_rdy", dbg_ready, 1);
    chk("dbg0_we", rf_we, 0);
    chk("dbg0_zd", zero_drop, 1);
    next_cycle();
    dbg_valid = 0;
    #3;
    chk("dbg0_zd_off", zero_drop, 0);
    next_cycle();

    // asynchronous abort in the middle of a clear
    clr_start = 1; next_cycle(); clr_start = 0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      #3;
      if (clr_busy && rf_addr == 5'd12) found = 1;
      else next_cycle();
    end
    chk("abort_reached_12", found, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", clr_busy, 0);
    chk("abort_done", clr_done, 0);
    chk("abort_rf_we", rf_we, 0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("abort_no_done", clr_done, 0);
      chk("abort_idle", clr_busy, 0);
      next_cycle();
    end
    clear_seq(99, 0, 0);

    clear_seq(99, 0, 1);
    chk("reg10_final", regs[10], 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL take parameters: DATA_WIDTH, default 32, register data width; ADDR_WIDTH, default 5, register address width; NREG = 2**ADDR_WIDTH is derived, not a parameter.
REQ-002 The block SHALL provide these ports:
- clk  in  1  clock, rising-edge state update
- rst  in  1  reset
- wb_we  in  1  pipeline writeback request, no backpressure
- wb_addr  in  ADDR_WIDTH  writeback destination
- wb_data  in  DATA_WIDTH  writeback data
- dbg_valid  in  1  debug write request
- dbg_ready  out  1  debug write accepted this cycle
- dbg_addr  in  ADDR_WIDTH  debug destination
- dbg_data  in  DATA_WIDTH  debug data
- clr_start  in  1  one-cycle pulse, start register clear sequence
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse, clear sequence finished
- zero_drop  out  1  one-cycle pulse, accepted write to register 0 discarded
- rf_we  out  1  register file write enable
- rf_addr  out  ADDR_WIDTH  register file write address
- rf_data  out  DATA_WIDTH  register file write data
REQ-003 Reset rst SHALL be asynchronous, active-high.

Function
REQ-004 rf_we/rf_addr/rf_data SHALL be combinational from current state and inputs, so the register file commits in the same cycle (falling edge).
REQ-005 Fixed priority SHALL be wb > clear sequencer > dbg; exactly one source drives rf_* per cycle.
REQ-006 When wb_we=1: rf_addr=wb_addr, rf_data=wb_data, rf_we=(wb_addr!=0).
REQ-007 The FSM SHALL have states IDLE and CLEAR; a 5-bit-wide (ADDR_WIDTH) counter clr_idx holds the next clear address.
REQ-008 IDLE, clr_start=1 -> CLEAR next cycle, clr_idx=1; clr_busy=1 from that cycle.
REQ-009 In CLEAR with wb_we=0: rf_we=1, rf_addr=clr_idx, rf_data=0, clr_idx increments; with wb_we=1 the clear step stalls (clr_idx held).
REQ-010 The clear write at clr_idx=NREG-1 SHALL be the last; next cycle state=IDLE, clr_busy=0, clr_done=1 for exactly one cycle.
REQ-011 Clear SHALL take NREG-1 cycles plus one cycle per stalled cycle; register 0 is never written.
REQ-012 clr_start while in CLEAR, or in the same cycle clr_done is high, SHALL be ignored.
REQ-013 dbg_ready SHALL be 1 only when state=IDLE, clr_start=0 and wb_we=0; a transfer occurs when dbg_valid & dbg_ready.
REQ-014 On a debug transfer: rf_addr=dbg_addr, rf_data=dbg_data, rf_we=(dbg_addr!=0).
REQ-015 zero_drop SHALL pulse in the cycle of a wb write or debug transfer with address 0; rf_we=0 then.
REQ-016 dbg_valid held with dbg_ready=0 SHALL produce no write; requester holds addr/data until transfer.
REQ-017 With no active source, rf_we=0, rf_addr=0, rf_data=0.
REQ-018 clr_start and dbg_valid in the same IDLE cycle: clear wins, debug waits (dbg_ready=0).

Reset
REQ-019 Asserting rst SHALL immediately force state=IDLE, clr_idx=0, clr_busy=0, clr_done=0; combinational outputs follow from that state and the inputs.
REQ-020 rst during CLEAR SHALL abort the sequence with no clr_done pulse; registers already cleared stay cleared; restart requires a new clr_start.
REQ-021 First state update after rst deassertion SHALL occur on the next rising clk edge.

Verification
REQ-022 wb_we=1, wb_addr=9, wb_data=5 with dbg_valid=1 -> rf_we=1, rf_addr=9, rf_data=5, dbg_ready=0 same cycle; debug accepted the first cycle wb_we=0.
REQ-023 clr_start pulse, wb_we=0 throughout -> rf_addr steps 1..31 with rf_data=0 over 31 cycles, clr_done pulses once, clr_busy then 0; register file regs 9,10 read 0.
REQ-024 clr_start, then wb_we=1 for 3 cycles mid-clear -> clear completes in 34 cycles, no address skipped or repeated, wb writes appear on rf_* during stall.
REQ-025 dbg_valid=1, dbg_addr=0, dbg_data=0xDEADBEEF in IDLE -> dbg_ready=1, rf_we=0, zero_drop=1 one cycle.
REQ-026 rst asserted at clr_idx=12 -> clr_busy=0 immediately, no clr_done; after release, new clr_start restarts at address 1.
REQ-027 clr_start and dbg_valid (dbg_addr=10, dbg_data=7) same IDLE cycle -> clear runs first, debug write of 7 to register 10 after clr_done, final reg 10 = 7.
